// File: rtl/video_mode_pkg.sv
// Shared encodings for the video mode controller.
// Also provides the target-mode step used by the staging logic.
package video_mode_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t BG_CAMERA  = 2'b00;
    localparam mode_t BG_CHANNEL = 2'b01;
    localparam mode_t BG_THRESH  = 2'b10;
    localparam mode_t BG_YMASK   = 2'b11;

    localparam mode_t TGT_NONE      = 2'b00;
    localparam mode_t TGT_CROSSHAIR = 2'b01;
    localparam mode_t TGT_SPRITE    = 2'b10;

    // Code 11 has no target meaning; it falls back to none.
    function automatic mode_t next_target(input mode_t cur);
        unique case (cur)
            TGT_NONE:      next_target = TGT_CROSSHAIR;
            TGT_CROSSHAIR: next_target = TGT_SPRITE;
            default:       next_target = TGT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, hold-time debounce and rising-edge press detect
// for one raw push-button.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 371250
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic raw_in,
    output logic level_out,
    output logic press_out
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync_1;
    logic          sync_2;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            level_out <= 1'b0;
            level_q   <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_1  <= raw_in;
            sync_2  <= sync_1;
            level_q <= level_out;
            if (sync_2 == level_out) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_out <= sync_2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press_out = level_out & ~level_q;

endmodule

// File: rtl/video_mode_controller.sv
// Debounced mode-cycle buttons, frame-boundary commit of background and
// target selects, and a frame-counted crosshair colour blink.
module video_mode_controller
    import video_mode_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 371250,
    parameter int          BLINK_FRAMES    = 30,
    parameter logic [23:0] COLOR_A         = 24'h00FF00,
    parameter logic [23:0] COLOR_B         = 24'hFFFFFF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        btn_bg_in,
    input  logic        btn_target_in,
    input  logic        new_frame_in,
    output logic [1:0]  bg_out,
    output logic [1:0]  target_out,
    output logic [23:0] crosshair_color_out,
    output logic        mode_changed_out
);

    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic          bg_press;
    logic          tgt_press;
    logic          bg_level;
    logic          tgt_level;
    logic          unused_levels;
    mode_t         staged_bg;
    mode_t         staged_tgt;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;

    assign unused_levels = bg_level ^ tgt_level;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bg_deb (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .raw_in    (btn_bg_in),
        .level_out (bg_level),
        .press_out (bg_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_tgt_deb (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .raw_in    (btn_target_in),
        .level_out (tgt_level),
        .press_out (tgt_press)
    );

    // Commit samples the staged values from before this cycle's presses.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            staged_bg           <= BG_CAMERA;
            staged_tgt          <= TGT_NONE;
            bg_out              <= BG_CAMERA;
            target_out          <= TGT_NONE;
            mode_changed_out    <= 1'b0;
            frame_cnt           <= '0;
            blink_phase         <= 1'b0;
            crosshair_color_out <= COLOR_A;
        end else begin
            if (bg_press)
                staged_bg <= staged_bg + 2'd1;
            if (tgt_press)
                staged_tgt <= next_target(staged_tgt);
            mode_changed_out <= 1'b0;
            if (new_frame_in) begin
                bg_out           <= staged_bg;
                target_out       <= staged_tgt;
                mode_changed_out <= (staged_bg != bg_out) ||
                                    (staged_tgt != target_out);
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt           <= '0;
                    blink_phase         <= ~blink_phase;
                    crosshair_color_out <= blink_phase ? COLOR_A : COLOR_B;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

endmodule
